// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings for the Pong match sequencer.
// States, winner codes, BCD digit width and a winner helper.
package pong_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_P1   = 2'd1,
    W_P2   = 2'd2,
    W_TIE  = 2'd3
  } win_e;

  function automatic win_e win_code(
    input logic [3:0] s1,
    input logic [3:0] s2
  );
    if (s1 > s2) return W_P1;
    if (s2 > s1) return W_P2;
    return W_TIE;
  endfunction

endpackage

// File: rtl/pong_match_sequencer_bcd_countdown.sv
// bcd_countdown: M:SS BCD countdown, loads INIT_MIN:00, holds at 0:00.
// Ports: clk, rst (async low), load_i, dec_i -> min_o, sec10_o, sec1_o, zero_o.
module bcd_countdown
  import pong_pkg::*;
#(
  parameter int unsigned INIT_MIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] min_o,
  output logic [BCD_W-1:0] sec10_o,
  output logic [BCD_W-1:0] sec1_o,
  output logic             zero_o
);

  localparam logic [BCD_W-1:0] MIN0 = BCD_W'(INIT_MIN);
  localparam logic [BCD_W-1:0] NINE = BCD_W'(9);
  localparam logic [BCD_W-1:0] FIVE = BCD_W'(5);
  localparam logic [BCD_W-1:0] ONE  = BCD_W'(1);

  logic [BCD_W-1:0] min_q, min_d;
  logic [BCD_W-1:0] s10_q, s10_d;
  logic [BCD_W-1:0] s1_q, s1_d;

  assign zero_o = (min_q == '0) && (s10_q == '0) && (s1_q == '0);

  always_comb begin
    min_d = min_q;
    s10_d = s10_q;
    s1_d  = s1_q;
    if (load_i) begin
      min_d = MIN0;
      s10_d = '0;
      s1_d  = '0;
    end else if (dec_i && !zero_o) begin
      if (s1_q != '0) begin
        s1_d = s1_q - ONE;
      end else begin
        s1_d = NINE;
        if (s10_q != '0) begin
          s10_d = s10_q - ONE;
        end else begin
          s10_d = FIVE;
          min_d = min_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q <= MIN0;
      s10_q <= '0;
      s1_q  <= '0;
    end else begin
      min_q <= min_d;
      s10_q <= s10_d;
      s1_q  <= s1_d;
    end
  end

  assign min_o   = min_q;
  assign sec10_o = s10_q;
  assign sec1_o  = s1_q;

endmodule

// File: rtl/pong_match_sequencer.sv
// pong_match_sequencer: IDLE/SERVE/PLAY/OVER match FSM, scores, BCD timer.
// In: clk, rst, tick_1hz, start, miss1, miss2 (pause if PONG_PAUSE_EN).
// Out: state, play_en, serve, score1/2, t_min/t_sec10/t_sec1, winner, game_over.
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned MATCH_MIN     = 2,
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned SERVE_DELAY_S = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             start,
  input  logic             miss1,
  input  logic             miss2,
`ifdef PONG_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       state,
  output logic             play_en,
  output logic             serve,
  output logic [3:0]       score1,
  output logic [3:0]       score2,
  output logic [BCD_W-1:0] t_min,
  output logic [BCD_W-1:0] t_sec10,
  output logic [BCD_W-1:0] t_sec1,
  output logic [1:0]       winner,
  output logic             game_over
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [3:0] SD  = 4'(SERVE_DELAY_S);

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [3:0] cnt_q, cnt_d;
  logic       serve_q, serve_d;
  logic       start_q;
  logic       start_rise;
  logic       run;
  logic       m1, m2;
  logic       tmr_load, tmr_dec, tmr_zero;

  assign start_rise = start & ~start_q;
  assign m1 = miss1 & run;
  assign m2 = miss2 & run;

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    cnt_d    = cnt_q;
    serve_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          score1_d = '0;
          score2_d = '0;
          tmr_load = 1'b1;
          cnt_d    = SD;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (tmr_zero) begin
          state_d = OVER;
        end else if (tick_1hz) begin
          tmr_dec = 1'b1;
          if (cnt_q == 4'd1) begin
            state_d = PLAY;
            serve_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      PLAY: begin
        tmr_dec = tick_1hz & run;
        // a double miss is a replay: no point awarded
        if (m1 & ~m2) score2_d = sat_inc(score2_q);
        if (m2 & ~m1) score1_d = sat_inc(score1_q);
        if (score1_d >= WIN || score2_d >= WIN || tmr_zero) begin
          state_d = OVER;
        end else if (m1 | m2) begin
          state_d = SERVE;
          cnt_d   = SD;
        end
      end
      OVER: begin
        if (start_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      score1_q <= '0;
      score2_q <= '0;
      cnt_q    <= '0;
      serve_q  <= 1'b0;
      // a button held through reset must not start a match
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      cnt_q    <= cnt_d;
      serve_q  <= serve_d;
      start_q  <= start;
    end
  end

`ifdef PONG_PAUSE_EN
  logic pause_q, paused_q, paused_d;

  always_comb begin
    paused_d = paused_q;
    if (state_d != PLAY) paused_d = 1'b0;
    else if (state_q == PLAY && pause && !pause_q) paused_d = ~paused_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      pause_q  <= pause;
      paused_q <= paused_d;
    end
  end

  assign run = ~paused_q;
`else
  assign run = 1'b1;
`endif

  bcd_countdown #(
    .INIT_MIN (MATCH_MIN)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .dec_i   (tmr_dec),
    .min_o   (t_min),
    .sec10_o (t_sec10),
    .sec1_o  (t_sec1),
    .zero_o  (tmr_zero)
  );

  assign state     = state_q;
  assign play_en   = (state_q == PLAY) & run;
  assign serve     = serve_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign game_over = (state_q == OVER);
  assign winner    = game_over ? win_code(score1_q, score2_q) : W_NONE;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// tb_pong_match_sequencer: directed scenarios plus random play
// against a seconds-based reference model of the match rules.
module tb_pong_match_sequencer;

  localparam int MM = 2;
  localparam int WS = 3;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick, start, miss1, miss2;
  logic [1:0] state, winner;
  logic       play_en, serve, game_over;
  logic [3:0] score1, score2, t_min, t_sec10, t_sec1;
  logic [26:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  int m_st, m_s1, m_s2, m_secs, m_cnt;
  bit m_prev, m_srv;

  always #5 clk = ~clk;

  pong_match_sequencer #(
    .MATCH_MIN     (MM),
    .WIN_SCORE     (WS),
    .SERVE_DELAY_S (SD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick),
    .start     (start),
    .miss1     (miss1),
    .miss2     (miss2),
`ifdef PONG_PAUSE_EN
    .pause     (1'b0),
`endif
    .state     (state),
    .play_en   (play_en),
    .serve     (serve),
    .score1    (score1),
    .score2    (score2),
    .t_min     (t_min),
    .t_sec10   (t_sec10),
    .t_sec1    (t_sec1),
    .winner    (winner),
    .game_over (game_over)
  );

  assign obs = {state, play_en, serve, score1, score2,
                t_min, t_sec10, t_sec1, winner, game_over};

  task automatic model_reset();
    m_st = 0; m_s1 = 0; m_s2 = 0;
    m_secs = MM * 60; m_cnt = 0;
    m_prev = 1'b1; m_srv = 1'b0;
  endtask

  // match rules, timer kept as plain seconds remaining
  task automatic model_step(input bit st, tk, b1, b2);
    bit rise;
    int old, n1, n2;
    rise = st && !m_prev;
    m_prev = st;
    m_srv = 1'b0;
    old = m_secs;
    case (m_st)
      0: if (rise) begin
        m_s1 = 0; m_s2 = 0; m_secs = MM * 60;
        m_cnt = SD; m_st = 1;
      end
      1: if (old == 0) m_st = 3;
         else if (tk) begin
           m_secs--; m_cnt--;
           if (m_cnt == 0) begin m_st = 2; m_srv = 1'b1; end
         end
      2: begin
        n1 = m_s1; n2 = m_s2;
        if (b1 && !b2) n2 = (m_s2 < 15) ? m_s2 + 1 : 15;
        if (b2 && !b1) n1 = (m_s1 < 15) ? m_s1 + 1 : 15;
        if (tk && old > 0) m_secs--;
        m_s1 = n1; m_s2 = n2;
        if (n1 == WS || n2 == WS || old == 0) m_st = 3;
        else if (b1 || b2) begin m_st = 1; m_cnt = SD; end
      end
      default: if (rise) m_st = 0;
    endcase
  endtask

  function automatic logic [26:0] exp_vec();
    int w;
    w = 0;
    if (m_st == 3) w = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
    return {2'(m_st), m_st == 2, m_srv, 4'(m_s1), 4'(m_s2),
            4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
            2'(w), m_st == 3};
  endfunction

  task automatic step(input bit st, tk, b1, b2);
    start = st; tick = tk; miss1 = b1; miss2 = b2;
    @(posedge clk);
    model_step(st, tk, b1, b2);
    @(negedge clk);
  endtask

  task automatic two_ticks();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    start = 1'b1;
    #2 rst = 1'b0;
    #1 model_reset();
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_vec got %h exp %h", obs, exp_vec());
    end
    n_chk++;
    if (t_min !== 4'd2 || state !== 2'd0 || winner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_fields got st=%0d min=%0d w=%0d exp 0/2/0",
               state, t_min, winner);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_chk++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL held_start got st=%0d exp 0", state);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_serve_entry();
    step(1, 0, 0, 0);
    n_chk++;
    if (state !== 2'd1 || t_min !== 4'd2 || serve !== 1'b0) begin
      n_fail++;
      $display("FAIL start_serve got st=%0d min=%0d srv=%b exp 1/2/0",
               state, t_min, serve);
    end
    step(0, 1, 0, 0);
    n_chk++;
    if (state !== 2'd1 || t_sec1 !== 4'd9) begin
      n_fail++;
      $display("FAIL serve_tick1 got st=%0d s1=%0d exp 1/9", state, t_sec1);
    end
    step(0, 1, 0, 0);
    n_chk++;
    if ({state, serve, play_en, t_min, t_sec10, t_sec1}
        !== {2'd2, 1'b1, 1'b1, 4'd1, 4'd5, 4'd8}) begin
      n_fail++;
      $display("FAIL play_entry got st=%0d srv=%b pe=%b t=%0d:%0d%0d exp 2/1/1 1:58",
               state, serve, play_en, t_min, t_sec10, t_sec1);
    end
    step(0, 0, 0, 0);
    n_chk++;
    if (serve !== 1'b0 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL serve_pulse_len got srv=%b st=%0d exp 0/2", serve, state);
    end
  endtask

  task automatic test_miss();
    step(0, 0, 0, 1);
    n_chk++;
    if (score1 !== 4'd1 || state !== 2'd1 || play_en !== 1'b0) begin
      n_fail++;
      $display("FAIL miss2 got s1=%0d st=%0d pe=%b exp 1/1/0",
               score1, state, play_en);
    end
    two_ticks();
    n_chk++;
    if (state !== 2'd2 || serve !== 1'b1 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reserve got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_double_miss();
    step(0, 0, 1, 1);
    n_chk++;
    if (score1 !== 4'd1 || score2 !== 4'd0 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL double_miss got %0d:%0d st=%0d exp 1:0 st=1",
               score1, score2, state);
    end
    two_ticks();
  endtask

  task automatic test_win();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      if (i < 2) begin
        n_chk++;
        if (state !== 2'd1 || score2 !== 4'(i + 1)) begin
          n_fail++;
          $display("FAIL rally%0d got st=%0d s2=%0d exp 1/%0d",
                   i, state, score2, i + 1);
        end
        two_ticks();
      end
    end
    n_chk++;
    if ({state, winner, game_over, play_en, score2}
        !== {2'd3, 2'd2, 1'b1, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL win_p2 got st=%0d w=%0d go=%b pe=%b s2=%0d exp 3/2/1/0/3",
               state, winner, game_over, play_en, score2);
    end
    two_ticks();
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL over_frozen got %h exp %h", obs, exp_vec());
    end
    step(1, 0, 0, 0);
    n_chk++;
    if (state !== 2'd0 || winner !== 2'd0 || score2 !== 4'd3) begin
      n_fail++;
      $display("FAIL over_idle got st=%0d w=%0d s2=%0d exp 0/0/3",
               state, winner, score2);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_expiry();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_chk++;
    if (score1 !== 4'd0 || score2 !== 4'd0 || t_min !== 4'd2) begin
      n_fail++;
      $display("FAIL restart got %0d:%0d min=%0d exp 0:0 2", score1, score2, t_min);
    end
    two_ticks();
    step(0, 0, 0, 1); two_ticks();
    step(0, 0, 0, 1); two_ticks();
    step(0, 0, 1, 0); two_ticks();
    step(0, 0, 1, 0); two_ticks();
    n_chk++;
    if (score1 !== 4'd2 || score2 !== 4'd2 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL tie_setup got %0d:%0d st=%0d exp 2:2 st=2",
               score1, score2, state);
    end
    for (int i = 0; i < 200 && m_secs > 1; i++) step(0, 1, 0, 0);
    n_chk++;
    if ({state, t_min, t_sec10, t_sec1} !== {2'd2, 4'd0, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL at_0_01 got st=%0d t=%0d:%0d%0d exp 2 0:01",
               state, t_min, t_sec10, t_sec1);
    end
    step(0, 1, 0, 0);
    n_chk++;
    if (obs !== exp_vec() || {t_min, t_sec10, t_sec1} !== 12'h000) begin
      n_fail++;
      $display("FAIL expire got %h exp %h", obs, exp_vec());
    end
    step(0, 0, 0, 0);
    n_chk++;
    if (state !== 2'd3 || winner !== 2'd3 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_over got st=%0d w=%0d go=%b exp 3/3/1",
               state, winner, game_over);
    end
    two_ticks();
    step(0, 1, 0, 0);
    n_chk++;
    if ({state, t_min, t_sec10, t_sec1} !== {2'd3, 12'h000}) begin
      n_fail++;
      $display("FAIL hold_zero got st=%0d t=%0d:%0d%0d exp 3 0:00",
               state, t_min, t_sec10, t_sec1);
    end
    step(1, 0, 0, 0);
    n_chk++;
    if (state !== 2'd0 || winner !== 2'd0) begin
      n_fail++;
      $display("FAIL tie_idle got st=%0d w=%0d exp 0/0", state, winner);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_borrow_reset();
    step(1, 0, 0, 0);
    two_ticks();
    step(0, 0, 0, 1);
    two_ticks();
    for (int i = 0; i < 200 && m_secs > 60; i++) step(0, 1, 0, 0);
    n_chk++;
    if ({t_min, t_sec10, t_sec1} !== {4'd1, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL at_1_00 got %0d:%0d%0d exp 1:00", t_min, t_sec10, t_sec1);
    end
    step(0, 1, 0, 0);
    n_chk++;
    if ({t_min, t_sec10, t_sec1} !== {4'd0, 4'd5, 4'd9} || state !== 2'd2) begin
      n_fail++;
      $display("FAIL borrow got %0d:%0d%0d st=%0d exp 0:59 st=2",
               t_min, t_sec10, t_sec1, state);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({state, play_en, score1, score2, t_min, t_sec10, t_sec1}
        !== {2'd0, 1'b0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset got st=%0d pe=%b %0d:%0d t=%0d:%0d%0d exp 0/0 0:0 2:00",
               state, play_en, score1, score2, t_min, t_sec10, t_sec1);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0);
    n_chk++;
    if (serve !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL release got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    start = 1'b0; tick = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_serve_entry();
    test_miss();
    test_double_miss();
    test_win();
    test_expiry();
    test_borrow_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
